pipeline_hazard_sequencer: RTL
==============================

// Module: pipeline_hazard_sequencer
// PURPOSE
//  Central hazard sequencer for the 5-stage pipeline; drives the IF/ID/EX/MEM/WB register enables, flushes and bubble selects.
//  Resolves three hazard sources: load-use stalls from ID, taken branches resolved in EX, and multi-cycle data-memory waits in MEM.
//  Sits beside the ID stage and replaces per-hazard ad-hoc gating with one priority-ordered state machine.
//  Provides saturating stall and flush performance counters.
// PARAMETERS
//  REG_W        5    register-address width
//  CNT_W        16   width of each performance counter
//  MEM_TIMEOUT  64   MEM_WAIT cycles before mem_timeout is raised (>=2)
// PORTS
//  clk             in   1      pipeline clock
//  reset_n         in   1      synchronous reset, active-low
//  IF_ID_rs1       in   REG_W  rs1 of instruction in ID
//  IF_ID_rs2       in   REG_W  rs2 of instruction in ID
//  IF_ID_use_rs1   in   1      ID instruction reads rs1
//  IF_ID_use_rs2   in   1      ID instruction reads rs2
//  ID_EX_rd        in   REG_W  destination of instruction in EX
//  ID_EX_memRead   in   1      EX instruction is a load
//  EX_branch_taken in   1      branch/jump in EX redirects the PC this cycle
//  EX_MEM_memAcc   in   1      MEM-stage instruction accesses data memory
//  dmem_ready      in   1      data memory completes the access this cycle
//  pc_write        out  1      1 = PC updates
//  IF_ID_write     out  1      1 = IF/ID register loads
//  IF_ID_flush     out  1      1 = IF/ID loads a NOP
//  ID_EX_ctrl_sel  out  1      1 = real control into ID/EX; 0 = bubble (all-zero control)
//  pipe_hold       out  1      1 = ID/EX and EX/MEM registers hold
//  MEM_WB_bubble   out  1      1 = MEM/WB loads a bubble
//  mem_timeout     out  1      sticky error flag; cleared only by reset
//  stall_cnt       out  CNT_W  saturating count of stall cycles
//  flush_cnt       out  CNT_W  saturating count of applied flushes
// BEHAVIOUR
//  Clocking and reset
//   - Everything is sampled on the rising edge of clk.
//   - reset_n==0 at an edge: state<=S_RESET, pend_flush<=0, wait_cnt<=0, mem_timeout<=0, counters<=0.
//   - Reset mid-wait abandons the access with no further side effects.
//  Output timing
//   - Control outputs are combinational from the registered state plus the current inputs; zero-cycle reaction.
//  States
//   - S_RESET: occupied for exactly one cycle after reset is released, then goes to S_RUN.
//       outputs: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_ctrl_sel=0, pipe_hold=0, MEM_WB_bubble=1.
//       These are also the output values while reset is asserted.
//   - S_RUN: default state. Hazard detection, in priority order:
//       1 memwait = EX_MEM_memAcc & !dmem_ready.
//           Freeze: pc_write=0, IF_ID_write=0, pipe_hold=1, MEM_WB_bubble=1, ID_EX_ctrl_sel=1.
//           Next state S_MEM_WAIT. If EX_branch_taken is also set, pend_flush<=1 and no flush is applied now.
//       2 flush = EX_branch_taken | pend_flush.
//           IF_ID_flush=1, ID_EX_ctrl_sel=0, pc_write=1, IF_ID_write=1. Clears pend_flush.
//           A load-use hazard in the same cycle is ignored because the instruction in ID is squashed.
//       3 loaduse = ID_EX_memRead & ID_EX_rd!=0 & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)).
//           pc_write=0, IF_ID_write=0, ID_EX_ctrl_sel=0. Exactly one bubble per occurrence.
//       4 Otherwise all enables are 1 and all flush/bubble outputs are 0.
//   - S_MEM_WAIT: freeze outputs as in RUN item 1.
//       EX_branch_taken here sets pend_flush.
//       wait_cnt increments each cycle.
//       On dmem_ready: this cycle still freezes, but MEM_WB_bubble=0 so the result is captured.
//         Then go to S_RUN and clear wait_cnt. A pending flush applies in the first RUN cycle.
//       When wait_cnt reaches MEM_TIMEOUT-1: mem_timeout<=1 and the wait continues (no forced exit).
//  Counters
//   - stall_cnt +1 for every cycle with pc_write==0 in RUN or MEM_WAIT.
//   - flush_cnt +1 for every cycle with IF_ID_flush==1 in S_RUN.
//   - Both counters saturate at 2^CNT_W-1 and never wrap.
//  Register x0 never causes a load-use stall.
// TESTING
//  T1: ld x5 in EX, ID uses rs1=x5 -> exactly 1 cycle of pc_write=0, ID_EX_ctrl_sel=0; stall_cnt=1.
//  T2: ld x0 in EX, ID rs1=x0; and rs2 matches with use_rs2=0 -> no stall in either case.
//  T3: branch_taken and load-use in the same cycle -> IF_ID_flush=1, pc_write=1, flush_cnt=1, stall_cnt=0.
//  T4: memAcc with dmem_ready low for 3 cycles, branch_taken in 2nd cycle
//      -> 4 frozen cycles with MEM_WB_bubble=1,1,1,0; then one flush cycle; stall_cnt=4.
//  T5: MEM_TIMEOUT=4, dmem_ready held low 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 until reset.
//  T6: reset_n low during MEM_WAIT -> next cycle S_RESET outputs, pend_flush=0, counters=0; S_RUN one cycle after release.

Source files
------------

// File: rtl/pipeline_hazard_sequencer_if.sv
// rtl/pipeline_hazard_sequencer_if.sv - hazard source / pipeline control bundle
// Purpose: groups the hazard inputs seen by the sequencer and the stage
//          enable / flush / bubble controls it drives back into the pipeline.
// Ports (signals):
//   IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2 : source operands of ID instruction
//   ID_EX_rd, ID_EX_memRead                            : destination / load flag of EX instruction
//   EX_branch_taken                                    : EX redirects the PC this cycle
//   EX_MEM_memAcc, dmem_ready                          : MEM-stage access and its completion
//   pc_write, IF_ID_write, IF_ID_flush, ID_EX_ctrl_sel,
//   pipe_hold, MEM_WB_bubble                           : pipeline register controls
// Modports: master = pipeline side, slave = sequencer side.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] IF_ID_rs1;
    logic [REG_W-1:0] IF_ID_rs2;
    logic             IF_ID_use_rs1;
    logic             IF_ID_use_rs2;
    logic [REG_W-1:0] ID_EX_rd;
    logic             ID_EX_memRead;
    logic             EX_branch_taken;
    logic             EX_MEM_memAcc;
    logic             dmem_ready;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_ctrl_sel;
    logic             pipe_hold;
    logic             MEM_WB_bubble;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        output ID_EX_rd, ID_EX_memRead, EX_branch_taken, EX_MEM_memAcc, dmem_ready,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_ctrl_sel, pipe_hold, MEM_WB_bubble
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2,
        input  ID_EX_rd, ID_EX_memRead, EX_branch_taken, EX_MEM_memAcc, dmem_ready,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_ctrl_sel, pipe_hold, MEM_WB_bubble
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - priority-ordered 5-stage pipeline hazard sequencer
// Purpose: resolves data-memory waits, taken branches and load-use hazards with one
//          state machine and keeps saturating stall / flush counters.
// Ports:
//   clk          in   pipeline clock
//   reset_n      in   synchronous reset, active-low
//   hz           slave modport of pipeline_hazard_sequencer_if (hazard sources in, controls out)
//   mem_timeout  out  sticky flag: a memory wait lasted MEM_TIMEOUT cycles
//   stall_cnt    out  saturating count of cycles with the PC held
//   flush_cnt    out  saturating count of flushes applied in RUN
module pipeline_hazard_sequencer #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    pipeline_hazard_sequencer_if.slave hz,
    output logic                       mem_timeout,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              pend_flush;
    logic              pend_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              timeout_hit;

    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              memwait;
    logic              load_use;

    assign rs1     = hz.IF_ID_rs1;
    assign rs2     = hz.IF_ID_rs2;
    assign rd      = hz.ID_EX_rd;
    assign memwait = hz.EX_MEM_memAcc & ~hz.dmem_ready;
    // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
    assign load_use = hz.ID_EX_memRead && (rd != '0) &&
                      ((hz.IF_ID_use_rs1 && (rs1 == rd)) ||
                       (hz.IF_ID_use_rs2 && (rs2 == rd)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_RESET;
            pend_flush  <= 1'b0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state      <= state_next;
            pend_flush <= pend_next;
            wait_cnt   <= wait_next;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            if ((state == S_RUN || state == S_MEM_WAIT) && !hz.pc_write && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (state == S_RUN && hz.IF_ID_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Defaults are the reset-time outputs; they also apply while reset_n is low.
    always_comb begin
        state_next        = state;
        pend_next         = pend_flush;
        wait_next         = wait_cnt;
        timeout_hit       = 1'b0;
        hz.pc_write       = 1'b0;
        hz.IF_ID_write    = 1'b0;
        hz.IF_ID_flush    = 1'b1;
        hz.ID_EX_ctrl_sel = 1'b0;
        hz.pipe_hold      = 1'b0;
        hz.MEM_WB_bubble  = 1'b1;
        if (reset_n) begin
            case (state)
                S_RESET: begin
                    state_next = S_RUN;
                end
                S_RUN: begin
                    if (memwait) begin
                        // Freeze everything; a branch seen now is remembered, not applied.
                        hz.IF_ID_flush    = 1'b0;
                        hz.ID_EX_ctrl_sel = 1'b1;
                        hz.pipe_hold      = 1'b1;
                        state_next        = S_MEM_WAIT;
                        if (hz.EX_branch_taken) begin
                            pend_next = 1'b1;
                        end
                    end else if (hz.EX_branch_taken || pend_flush) begin
                        // ID instruction is squashed, so any load-use hazard is moot.
                        hz.pc_write      = 1'b1;
                        hz.IF_ID_write   = 1'b1;
                        hz.MEM_WB_bubble = 1'b0;
                        pend_next        = 1'b0;
                    end else if (load_use) begin
                        hz.IF_ID_flush   = 1'b0;
                        hz.MEM_WB_bubble = 1'b0;
                    end else begin
                        hz.pc_write       = 1'b1;
                        hz.IF_ID_write    = 1'b1;
                        hz.IF_ID_flush    = 1'b0;
                        hz.ID_EX_ctrl_sel = 1'b1;
                        hz.MEM_WB_bubble  = 1'b0;
                    end
                end
                S_MEM_WAIT: begin
                    hz.IF_ID_flush    = 1'b0;
                    hz.ID_EX_ctrl_sel = 1'b1;
                    hz.pipe_hold      = 1'b1;
                    if (hz.EX_branch_taken) begin
                        pend_next = 1'b1;
                    end
                    if (wait_cnt == WAIT_LAST) begin
                        timeout_hit = 1'b1;
                    end
                    if (hz.dmem_ready) begin
                        // Last frozen cycle: let MEM/WB capture the load result.
                        hz.MEM_WB_bubble = 1'b0;
                        state_next       = S_RUN;
                        wait_next        = '0;
                    end else if (wait_cnt != WAIT_LAST) begin
                        wait_next = wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = S_RESET;
                end
            endcase
        end
    end
endmodule
